alu_seq: RTL and testbench

Parametrised sequential ALU for the RSA datapath, the successor to the combinational add/sub/mod execute-stage ALU. It performs wrapping add, subtract with borrow, modular multiply and modular exponentiation at a configurable width. Every operation runs under a single start/busy/done handshake. The modular operations use constant-time iterative schedules, so encryption and decryption latency is independent of the operand data.

---
 rtl/alu_pkg.sv | 20 ++
 rtl/modmul_iter.sv | 59 +++++
 rtl/alu_seq.sv | 165 ++++++++++++++++
 tb/tb_alu_seq.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode and FSM state types for the sequential RSA datapath ALU.
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD    = 2'b00,
    OP_SUB    = 2'b01,
    OP_MODMUL = 2'b10,
    OP_MODEXP = 2'b11
  } alu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    ALU1,
    MUL,
    EXP_SQ,
    EXP_MUL,
    FIN
  } alu_state_t;

endpackage

// File: rtl/modmul_iter.sv
// Interleaved shift-add modular multiplier: one exponent-independent bit-step per cycle.
module modmul_iter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         go,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] m,
  output logic [W-1:0] p,
  output logic         rdy
);

  localparam int unsigned CW = $clog2(W + 1);

  logic [W+1:0]  acc_q;
  logic [W+1:0]  x_q;
  logic [W+1:0]  m_q;
  logic [W-1:0]  y_q;
  logic [CW-1:0] cnt_q;
  logic          run_q;
  logic [W+1:0]  dbl;
  logic [W+1:0]  s1;

  // p is the reduced value after the step taken at the coming edge, so on the
  // rdy cycle the caller can consume it and relaunch go on that same edge.
  always_comb begin
    dbl = (acc_q << 1) + (y_q[W-1] ? x_q : '0);
    s1  = (dbl >= m_q) ? dbl - m_q : dbl;
    p   = W'((s1 >= m_q) ? s1 - m_q : s1);
  end

  assign rdy = run_q && (cnt_q == CW'(W - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      x_q   <= '0;
      m_q   <= '0;
      y_q   <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else if (go) begin
      acc_q <= '0;
      x_q   <= {2'b00, x};
      m_q   <= {2'b00, m};
      y_q   <= y;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= {2'b00, p};
      y_q   <= {y_q[W-2:0], 1'b0};
      cnt_q <= cnt_q + CW'(1);
      if (rdy) run_q <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Sequential ALU: add/sub plus constant-time modular multiply and exponentiation
// under a single start/busy/done handshake.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         z,
  output logic         c,
  output logic         err
);

  localparam int unsigned BW = $clog2(W);

  alu_state_t    state_q, state_d;
  alu_op_t       op_in, op_q;
  logic [W-1:0]  a_q, b_q, m_q, r_q;
  logic [W-1:0]  r_init, r_next, ix, iy, im, p;
  logic [BW-1:0] bit_q;
  logic          bad_q, pre_bad, go, rdy, is_sub;
  logic [W:0]    sum;

  assign op_in   = alu_op_t'(op);
  assign pre_bad = (op_in == OP_MODMUL || op_in == OP_MODEXP) && (m == '0 || a >= m);
  assign r_init  = (m == W'(1)) ? '0 : W'(1);
  assign r_next  = b_q[bit_q] ? p : r_q;
  assign is_sub  = (op_q == OP_SUB);
  assign sum     = {1'b0, a_q} + {1'b0, is_sub ? ~b_q : b_q} + (W+1)'(is_sub);
  assign busy    = (state_q != IDLE);

  modmul_iter #(.W(W)) u_mul (
    .clk (clk),
    .rst (rst),
    .go  (go),
    .x   (ix),
    .y   (iy),
    .m   (im),
    .p   (p),
    .rdy (rdy)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // The multiplier is launched on the accept edge straight from the ports,
  // later phases chain from its same-edge result so no gap cycles appear.
  always_comb begin
    state_d = state_q;
    go      = 1'b0;
    ix      = r_q;
    iy      = r_q;
    im      = m_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          if (pre_bad || op_in == OP_ADD || op_in == OP_SUB) begin
            state_d = ALU1;
          end else if (op_in == OP_MODMUL) begin
            state_d = MUL;
            go = 1'b1;
            ix = a;
            iy = b;
            im = m;
          end else begin
            state_d = EXP_SQ;
            go = 1'b1;
            ix = r_init;
            iy = r_init;
            im = m;
          end
        end
      end
      ALU1, FIN: state_d = IDLE;
      MUL: if (rdy) state_d = FIN;
      EXP_SQ: begin
        if (rdy) begin
          state_d = EXP_MUL;
          go = 1'b1;
          ix = p;
          iy = a_q;
        end
      end
      EXP_MUL: begin
        if (rdy) begin
          if (bit_q == '0) begin
            state_d = FIN;
          end else begin
            state_d = EXP_SQ;
            go = 1'b1;
            ix = r_next;
            iy = r_next;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q   <= OP_ADD;
      a_q    <= '0;
      b_q    <= '0;
      m_q    <= '0;
      r_q    <= '0;
      bit_q  <= '0;
      bad_q  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      z      <= 1'b0;
      c      <= 1'b0;
      err    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            op_q  <= op_in;
            a_q   <= a;
            b_q   <= b;
            m_q   <= m;
            bad_q <= pre_bad;
            bit_q <= BW'(W - 1);
            r_q   <= r_init;
          end
        end
        ALU1: begin
          done   <= 1'b1;
          err    <= bad_q;
          result <= bad_q ? '0 : sum[W-1:0];
          z      <= bad_q ? 1'b1 : (sum[W-1:0] == '0);
          c      <= bad_q ? 1'b0 : (is_sub ? ~sum[W] : sum[W]);
        end
        MUL, EXP_SQ: if (rdy) r_q <= p;
        EXP_MUL: begin
          if (rdy) begin
            r_q <= r_next;
            if (bit_q != '0) bit_q <= bit_q - BW'(1);
          end
        end
        FIN: begin
          done   <= 1'b1;
          err    <= 1'b0;
          result <= r_q;
          z      <= (r_q == '0);
          c      <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq at W=8 and W=16: reference model results are
// queued on issue and compared with the DUT when done pulses.
module tb_alu_seq;

  localparam logic [1:0] ADD = 2'd0, SUB = 2'd1, MMUL = 2'd2, MEXP = 2'd3;

  typedef struct packed {
    logic [63:0] res;
    logic        z;
    logic        c;
    logic        err;
    logic [31:0] due;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start8 = 1'b0, start16 = 1'b0;
  logic [1:0]  op8 = '0, op16 = '0;
  logic [7:0]  a8 = '0, b8 = '0, m8 = '0;
  logic [15:0] a16 = '0, b16 = '0, m16 = '0;
  logic        busy8, done8, z8, c8, err8;
  logic        busy16, done16, z16, c16, err16;
  logic [7:0]  res8;
  logic [15:0] res16;

  alu_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op(op8), .a(a8), .b(b8), .m(m8),
    .busy(busy8), .done(done8), .result(res8), .z(z8), .c(c8), .err(err8)
  );

  alu_seq #(.W(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .op(op16), .a(a16), .b(b16), .m(m16),
    .busy(busy16), .done(done16), .result(res16), .z(z16), .c(c16), .err(err16)
  );

  always #5 clk = ~clk;

  logic [31:0] cyc = '0;
  always @(posedge clk) cyc <= cyc + 1;

  bit   wide = 1'b0;
  rec_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic cur_done, cur_busy;
  rec_t cur;
  always_comb begin
    cur_done = wide ? done16 : done8;
    cur_busy = wide ? busy16 : busy8;
    cur.res  = wide ? {48'd0, res16} : {56'd0, res8};
    cur.z    = wide ? z16 : z8;
    cur.c    = wide ? c16 : c8;
    cur.err  = wide ? err16 : err8;
    cur.due  = cyc;
  end

  function automatic rec_t model(input int unsigned w, input logic [1:0] o,
                                 input longint unsigned av, bv, mv, input logic [31:0] acc);
    longint unsigned mask = (64'd1 << w) - 1;
    longint unsigned s, r, bs, e;
    int unsigned lat = 1;
    rec_t t = '0;
    if (o == ADD) begin
      s = av + bv;
      t.res = s & mask;
      t.c = ((s >> w) & 1) != 0;
    end else if (o == SUB) begin
      t.res = (av - bv) & mask;
      t.c = av < bv;
    end else if (mv == 0 || av >= mv) begin
      t.err = 1'b1;
    end else if (o == MMUL) begin
      t.res = (av * bv) % mv;
      lat = w + 1;
    end else begin
      r = 1 % mv;
      bs = av % mv;
      e = bv;
      while (e != 0) begin
        if (e[0]) r = (r * bs) % mv;
        bs = (bs * bs) % mv;
        e = e >> 1;
      end
      t.res = r;
      lat = 2 * w * w + 1;
    end
    t.z = (t.res == 0);
    t.due = acc + lat;
    return t;
  endfunction

  // Drive one request at the current negedge; accepted at the next posedge.
  task automatic drive(input logic [1:0] o, input longint unsigned av, bv, mv);
    if (wide) begin
      op16 = o; a16 = 16'(av); b16 = 16'(bv); m16 = 16'(mv); start16 = 1'b1;
    end else begin
      op8 = o; a8 = 8'(av); b8 = 8'(bv); m8 = 8'(mv); start8 = 1'b1;
    end
    q.push_back(model(wide ? 16 : 8, o, av, bv, mv, cyc + 1));
    @(negedge clk);
    start8 = 1'b0;
    start16 = 1'b0;
  endtask

  task automatic wait_done(input int unsigned budget, output bit ok);
    ok = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (cur_done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy8, done8, res8, z8, c8, err8} !== '0) begin
      n_bad++;
      $display("FAIL reset_w8: got busy=%b done=%b res=%0d z=%b c=%b err=%b, want all 0",
               busy8, done8, res8, z8, c8, err8);
    end
    n_cmp++;
    if ({busy16, done16, res16, z16, c16, err16} !== '0) begin
      n_bad++;
      $display("FAIL reset_w16: got busy=%b done=%b res=%0d z=%b c=%b err=%b, want all 0",
               busy16, done16, res16, z16, c16, err16);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    rec_t e;
    bit ok;
    wide = 1'b0;
    drive(ADD, 200, 100, 0);
    wait_done(20, ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL add_w8: no done within 20 cycles, want res=%0d", e.res);
    end else if (cur !== e) begin
      n_bad++;
      $display("FAIL add_w8: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
               cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
    end
  endtask

  task automatic test_sub_back_to_back();
    rec_t e;
    bit ok;
    wide = 1'b0;
    drive(SUB, 5, 7, 0);
    for (int i = 0; i < 2; i++) begin
      wait_done(20, ok);
      e = q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL sub_b2b[%0d]: no done within 20 cycles, want res=%0d", i, e.res);
      end else if (cur !== e) begin
        n_bad++;
        $display("FAIL sub_b2b[%0d]: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
                 i, cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
      end
      if (i == 0) drive(SUB, 7, 7, 0);
    end
  endtask

  task automatic test_modmul_busy();
    rec_t e;
    bit ok;
    int spur = 0;
    wide = 1'b0;
    drive(MMUL, 100, 200, 251);
    n_cmp++;
    if (busy8 !== 1'b1) begin
      n_bad++;
      $display("FAIL modmul_busy_high: got busy=%b, want 1", busy8);
    end
    repeat (3) begin
      a8 = ~a8; b8 = b8 + 8'd3; op8 = ADD; start8 = 1'b1;
      @(negedge clk);
    end
    start8 = 1'b0;
    wait_done(30, ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL modmul_w8: no done within 30 cycles, want res=%0d", e.res);
    end else if (cur !== e) begin
      n_bad++;
      $display("FAIL modmul_w8: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
               cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
    end
    n_cmp++;
    if (busy8 !== 1'b0) begin
      n_bad++;
      $display("FAIL modmul_busy_at_done: got busy=%b, want 0", busy8);
    end
    repeat (12) begin
      @(negedge clk);
      if (done8) spur++;
    end
    n_cmp++;
    if (spur != 0) begin
      n_bad++;
      $display("FAIL modmul_ignored_start: got %0d extra done pulses, want 0", spur);
    end
  endtask

  task automatic test_mod_err();
    rec_t e;
    bit ok;
    wide = 1'b0;
    for (int i = 0; i < 2; i++) begin
      if (i == 0) drive(MMUL, 3, 5, 0);
      else        drive(MEXP, 9, 3, 9);
      wait_done(20, ok);
      e = q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL mod_err[%0d]: no done within 20 cycles, want err=1", i);
      end else if (cur !== e) begin
        n_bad++;
        $display("FAIL mod_err[%0d]: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
                 i, cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_modexp();
    rec_t e;
    bit ok;
    wide = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(MEXP, 4, (i == 0) ? 13 : 0, 497);
      wait_done(600, ok);
      e = q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL modexp_w16[%0d]: no done within 600 cycles, want res=%0d", i, e.res);
      end else if (cur !== e) begin
        n_bad++;
        $display("FAIL modexp_w16[%0d]: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
                 i, cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_mid();
    rec_t e;
    bit ok;
    wide = 1'b1;
    drive(MEXP, 4, 13, 497);
    repeat (200) @(negedge clk);
    rst = 1'b0;
    #1;
    q.delete();
    n_cmp++;
    if ({busy16, done16, res16, z16, c16, err16} !== '0) begin
      n_bad++;
      $display("FAIL reset_mid: got busy=%b done=%b res=%0d z=%b c=%b err=%b, want all 0",
               busy16, done16, res16, z16, c16, err16);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    drive(ADD, 1, 1, 0);
    wait_done(20, ok);
    e = q.pop_front();
    n_cmp++;
    if (!ok) begin
      n_bad++;
      $display("FAIL add_after_reset: no done within 20 cycles, want res=%0d", e.res);
    end else if (cur !== e) begin
      n_bad++;
      $display("FAIL add_after_reset: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
               cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
    end
  endtask

  task automatic pick(output logic [1:0] o, output longint unsigned av, bv, mv);
    o  = 2'($urandom_range(0, 3));
    av = $urandom_range(0, 255);
    bv = $urandom_range(0, 255);
    mv = $urandom_range(0, 255);
    if (o[1] && mv != 0 && $urandom_range(0, 3) != 0) av = av % mv;
  endtask

  task automatic test_random_back_to_back();
    rec_t e;
    bit ok;
    logic [1:0] o;
    longint unsigned av, bv, mv;
    wide = 1'b0;
    pick(o, av, bv, mv);
    drive(o, av, bv, mv);
    for (int i = 0; i < 12; i++) begin
      wait_done(200, ok);
      e = q.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rand_b2b[%0d]: no done within 200 cycles, want res=%0d", i, e.res);
      end else if (cur !== e) begin
        n_bad++;
        $display("FAIL rand_b2b[%0d]: got res=%0d z=%0b c=%0b err=%0b cyc=%0d want res=%0d z=%0b c=%0b err=%0b cyc=%0d",
                 i, cur.res, cur.z, cur.c, cur.err, cur.due, e.res, e.z, e.c, e.err, e.due);
      end
      if (i < 11) begin
        pick(o, av, bv, mv);
        drive(o, av, bv, mv);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub_back_to_back();
    test_modmul_busy();
    test_mod_err();
    test_modexp();
    test_reset_mid();
    test_random_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got %0d compared", n_cmp);
    $fatal(1);
  end

endmodule
